// File: rtl/udp_reg_ring_master.sv
// Initiator of the UDP register ring: launches one host transaction at a time as a
// single-cycle request and returns the echoed data, or an error value, to the host.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module udp_reg_ring_master #(
   parameter int unsigned UDP_REG_SRC_WIDTH = 2,
   parameter int unsigned SRC_ID            = 0,
   parameter int unsigned TIMEOUT           = 255,
   parameter int unsigned TIMEOUT_WIDTH     = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              core_req,
   input  logic                              core_rd_wr_L,
   input  logic [`UDP_REG_ADDR_WIDTH-1:0]    core_addr,
   input  logic [`CPCI_NF2_DATA_WIDTH-1:0]   core_wr_data,
   output logic                              core_busy,
   output logic                              core_ack,
   output logic [`CPCI_NF2_DATA_WIDTH-1:0]   core_rd_data,
   output logic                              core_err,
   output logic [15:0]                       timeout_cnt,
   output logic [15:0]                       stray_cnt,
   output logic                              reg_req_out,
   output logic                              reg_ack_out,
   output logic                              reg_rd_wr_L_out,
   output logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_out,
   output logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_out,
   output logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_out,
   input  logic                              reg_req_in,
   input  logic                              reg_ack_in,
   input  logic                              reg_rd_wr_L_in,
   input  logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_in,
   input  logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_in,
   input  logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_in
);
   localparam int unsigned AW = `UDP_REG_ADDR_WIDTH;
   localparam int unsigned DW = `CPCI_NF2_DATA_WIDTH;
   localparam logic [DW-1:0]                ERR_DATA = DW'(32'hdead_beef);
   localparam logic [UDP_REG_SRC_WIDTH-1:0] MY_SRC   = UDP_REG_SRC_WIDTH'(SRC_ID);
   localparam logic [TIMEOUT_WIDTH-1:0]     TO_LIMIT = TIMEOUT_WIDTH'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                       state;
   logic [AW-1:0]                hold_addr;
   logic [TIMEOUT_WIDTH-1:0]     wait_cnt;
   logic                         ret_req;
   logic                         ret_ack;
   logic [AW-1:0]                ret_addr;
   logic [DW-1:0]                ret_data;
   logic [UDP_REG_SRC_WIDTH-1:0] ret_src;
   logic                         match;

   // Return is judged one cycle after it arrives, from the input capture flops.
   assign match = ret_req && (ret_src == MY_SRC) && (ret_addr == hold_addr);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         hold_addr       <= '0;
         wait_cnt        <= '0;
         ret_req         <= 1'b0;
         ret_ack         <= 1'b0;
         ret_addr        <= '0;
         ret_data        <= '0;
         ret_src         <= '0;
         core_busy       <= 1'b0;
         core_ack        <= 1'b0;
         core_rd_data    <= '0;
         core_err        <= 1'b0;
         timeout_cnt     <= '0;
         stray_cnt       <= '0;
         reg_req_out     <= 1'b0;
         reg_ack_out     <= 1'b0;
         reg_rd_wr_L_out <= 1'b0;
         reg_addr_out    <= '0;
         reg_data_out    <= '0;
         reg_src_out     <= '0;
      end else begin
         ret_req         <= reg_req_in;
         ret_ack         <= reg_ack_in;
         ret_addr        <= reg_addr_in;
         ret_data        <= reg_data_in;
         ret_src         <= reg_src_in;
         core_ack        <= 1'b0;
         core_err        <= 1'b0;
         reg_req_out     <= 1'b0;
         reg_ack_out     <= 1'b0;
         reg_rd_wr_L_out <= 1'b0;
         reg_addr_out    <= '0;
         reg_data_out    <= '0;
         reg_src_out     <= '0;

         // Anything returning that is not the awaited reply is dropped and counted.
         if (ret_req && !((state == WAIT) && match) && (stray_cnt != 16'hffff))
            stray_cnt <= stray_cnt + 16'd1;

         case (state)
            IDLE: begin
               if (core_req) begin
                  hold_addr       <= core_addr;
                  core_busy       <= 1'b1;
                  reg_req_out     <= 1'b1;
                  reg_rd_wr_L_out <= core_rd_wr_L;
                  reg_addr_out    <= core_addr;
                  reg_data_out    <= core_wr_data;
                  reg_src_out     <= MY_SRC;
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (match) begin
                  core_ack     <= 1'b1;
                  core_err     <= !ret_ack;
                  core_rd_data <= ret_ack ? ret_data : ERR_DATA;
                  state        <= DONE;
               end else if (wait_cnt == TO_LIMIT) begin
                  core_ack     <= 1'b1;
                  core_err     <= 1'b1;
                  core_rd_data <= ERR_DATA;
                  if (timeout_cnt != 16'hffff)
                     timeout_cnt <= timeout_cnt + 16'd1;
                  state        <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + TIMEOUT_WIDTH'(1);
               end
            end
            DONE: begin
               core_busy <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
